// File: rtl/shift_muldiv_seq.sv
// Sequential unsigned multiplier/divider: one shift-add or restoring shift-subtract step per clock.
// Optional POW2_FAST_EN: power-of-two divisors/multipliers bypass the iterative loop.
module shift_muldiv_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result_hi,
   output logic [WIDTH-1:0] result_lo,
   output logic             div_by_zero
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt;
   logic             mode_q;
   logic [WIDTH-1:0] b_q;
   // hi_q is the mul accumulator high half or the div partial remainder (one spare bit).
   logic [WIDTH:0]   hi_q, hi_next;
   logic [WIDTH-1:0] lo_q, lo_next;
   logic [WIDTH:0]   mul_sum, div_shift;
   logic             div_ge;
   logic             accept, b_zero, fast_hit;
   logic [WIDTH-1:0] fast_hi, fast_lo;

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign accept    = in_valid & in_ready;
   assign b_zero    = (b == '0);

`ifdef POW2_FAST_EN
   localparam int K_W = $clog2(WIDTH);

   logic [K_W-1:0]     k;
   logic [2*WIDTH-1:0] fast_prod;

   always_comb begin
      k = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (b[i]) k = K_W'(i);
      end
   end

   assign fast_hit  = !b_zero && ((b & (b - WIDTH'(1))) == '0);
   assign fast_prod = {{WIDTH{1'b0}}, a} << k;
   assign fast_hi   = mode ? (a & (b - WIDTH'(1))) : fast_prod[2*WIDTH-1:WIDTH];
   assign fast_lo   = mode ? (a >> k) : fast_prod[WIDTH-1:0];
`else
   assign fast_hit = 1'b0;
   assign fast_hi  = '0;
   assign fast_lo  = '0;
`endif

   // One iteration: mul shifts the accumulator right after a conditional add,
   // div shifts the next dividend bit into the remainder and restores on borrow.
   assign mul_sum   = hi_q + {1'b0, b_q & {WIDTH{lo_q[0]}}};
   assign div_shift = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
   assign div_ge    = (div_shift >= {1'b0, b_q});

   always_comb begin
      if (mode_q) begin
         hi_next = div_ge ? (div_shift - {1'b0, b_q}) : div_shift;
         lo_next = {lo_q[WIDTH-2:0], div_ge};
      end else begin
         hi_next = {1'b0, mul_sum[WIDTH:1]};
         lo_next = {mul_sum[0], lo_q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      // NOTE: default first so no path through the case leaves state_d unassigned (no latch).
      state_d = state_q;
      case (state_q)
         IDLE: if (accept) state_d = ((mode && b_zero) || fast_hit) ? DONE : RUN;
         RUN:  if (cnt == CNT_W'(1)) state_d = DONE;
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt         <= '0;
         mode_q      <= 1'b0;
         b_q         <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         result_hi   <= '0;
         result_lo   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (accept) begin
               mode_q <= mode;
               b_q    <= b;
               hi_q   <= '0;
               lo_q   <= a;
               cnt    <= CNT_W'(WIDTH);
               if (mode && b_zero) begin
                  result_hi   <= a;
                  result_lo   <= '1;
                  div_by_zero <= 1'b1;
               end else if (fast_hit) begin
                  result_hi   <= fast_hi;
                  result_lo   <= fast_lo;
                  div_by_zero <= 1'b0;
               end
            end
            RUN: begin
               cnt  <= cnt - CNT_W'(1);
               hi_q <= hi_next;
               lo_q <= lo_next;
               if (cnt == CNT_W'(1)) begin
                  result_hi   <= hi_next[WIDTH-1:0];
                  result_lo   <= lo_next;
                  div_by_zero <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_shift_muldiv_seq.sv
// Scoreboard bench for shift_muldiv_seq (WIDTH=8); build with and without POW2_FAST_EN.
module tb_shift_muldiv_seq;

   localparam int W = 8;
`ifdef POW2_FAST_EN
   localparam int PL = 0;
`else
   localparam int PL = 8;
`endif

   logic         clk = 1'b0;
   logic         rst_n, in_valid, in_ready, mode, out_valid, out_ready, div_by_zero;
   logic [W-1:0] a, b, result_hi, result_lo;

   shift_muldiv_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .mode(mode), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .result_hi(result_hi), .result_lo(result_lo), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   // lat = rising edges after the accept edge until out_valid is seen
   // (0 means out_valid is high in the cycle right after accept).
   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dbz;
      int           lat;
   } exp_t;

   typedef struct {
      logic         m;
      logic [W-1:0] va;
      logic [W-1:0] vb;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dbz;
      int           lat;
   } vec_t;

   vec_t vecs [13] = '{
      '{1'b0, 8'd13,  8'd11,  8'h00, 8'h8F, 1'b0, 8},
      '{1'b0, 8'd255, 8'd255, 8'hFE, 8'h01, 1'b0, 8},
      '{1'b1, 8'd200, 8'd7,   8'h04, 8'h1C, 1'b0, 8},
      '{1'b1, 8'd5,   8'd9,   8'h05, 8'h00, 1'b0, 8},
      '{1'b1, 8'd45,  8'd0,   8'h2D, 8'hFF, 1'b1, 0},
      '{1'b1, 8'd100, 8'd4,   8'h00, 8'h19, 1'b0, PL},
      '{1'b0, 8'd37,  8'd8,   8'h01, 8'h28, 1'b0, PL},
      '{1'b0, 8'd0,   8'd77,  8'h00, 8'h00, 1'b0, 8},
      '{1'b0, 8'd77,  8'd0,   8'h00, 8'h00, 1'b0, 8},
      '{1'b1, 8'd255, 8'd1,   8'h00, 8'hFF, 1'b0, PL},
      '{1'b1, 8'd200, 8'd128, 8'h48, 8'h01, 1'b0, PL},
      '{1'b1, 8'd255, 8'd255, 8'h00, 8'h01, 1'b0, 8},
      '{1'b0, 8'd255, 8'd1,   8'h00, 8'hFF, 1'b0, PL}
   };

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;
   int   acc_cyc = 0;
   bit   seen_valid = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic flag(input string name);
      tests++;
      fails++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Monitor: latency on the first out_valid cycle, data on the handshake cycle.
   initial forever begin
      @(negedge clk);
      if (out_valid && !seen_valid) begin
         seen_valid = 1'b1;
         if (sb.size() == 0) flag("unexpected_out_valid");
         else check("latency", 32'(cyc - acc_cyc), 32'(sb[0].lat));
      end
      if (out_valid && out_ready) begin
         seen_valid = 1'b0;
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check("result_hi", 32'(result_hi), 32'(e.hi));
            check("result_lo", 32'(result_lo), 32'(e.lo));
            check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
         end
      end
      if (in_valid && in_ready) acc_cyc = cyc + 1;
   end

   task automatic issue(input logic m, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input exp_t e, input bit push);
      int n = 0;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) flag("in_ready_timeout");
      in_valid = 1'b1;
      mode     = m;
      a        = va;
      b        = vb;
      if (push) sb.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
      mode     = ~m;
      a        = 8'hA5;
      b        = 8'h3C;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((sb.size() != 0 || !in_ready) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 200) flag("idle_timeout");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      mode      = 1'b0;
      a         = '0;
      b         = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_hi", 32'(result_hi), 32'd0);
      check("rst_lo", 32'(result_lo), 32'd0);
      check("rst_dbz", 32'(div_by_zero), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed vectors, issued back to back.
      foreach (vecs[i]) begin
         e = '{vecs[i].hi, vecs[i].lo, vecs[i].dbz, vecs[i].lat};
         issue(vecs[i].m, vecs[i].va, vecs[i].vb, e, 1'b1);
      end
      wait_idle();

      // Backpressure: 20*12 = 240 held for 5 cycles with in_valid pulses ignored.
      out_ready = 1'b0;
      e = '{8'h00, 8'hF0, 1'b0, 8};
      issue(1'b0, 8'd20, 8'd12, e, 1'b1);
      begin
         int n = 0;
         while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
         end
         if (!out_valid) flag("bp_out_valid_timeout");
      end
      for (int i = 0; i < 5; i++) begin
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_hi", 32'(result_hi), 32'h00);
         check("bp_lo", 32'(result_lo), 32'hF0);
         in_valid = i[0];
         a        = 8'd3;
         b        = 8'd3;
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_in_ready_after", 32'(in_ready), 32'd1);
      check("bp_out_valid_after", 32'(out_valid), 32'd0);
      wait_idle();

      // Reset in the middle of RUN aborts the op with no result presented.
      issue(1'b0, 8'd200, 8'd7, e, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("abort_in_ready", 32'(in_ready), 32'd1);
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_hi", 32'(result_hi), 32'd0);
      check("abort_lo", 32'(result_lo), 32'd0);
      check("abort_dbz", 32'(div_by_zero), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      e = '{8'h00, 8'h2A, 1'b0, 8};
      issue(1'b0, 8'd6, 8'd7, e, 1'b1);
      wait_idle();
      repeat (12) @(posedge clk);
      #1;
      check("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
